// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the datapath controller: FSM state encoding, the
// CR16-style major opcode / extended opcode values the decoder recognises,
// condition-code values for Bcond/Jcond, and bit positions in the flags bus.
// No ports; imported by datapath_controller and cond_eval.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXEC    = 2'd2,
    ST_LOAD_WB = 2'd3
  } state_t;

  // major opcode, instr[15:12]
  localparam logic [3:0] OP_RR        = 4'b0000;
  localparam logic [3:0] OP_LOADSTORE = 4'b0100;
  localparam logic [3:0] OP_BCOND     = 4'b1100;
  localparam logic [3:0] OP_CMPI      = 4'b1011;

  // extended opcode, instr[7:4]
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // condition codes, instr[11:8] of Bcond/Jcond
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  // flags bus bit positions
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_C = 3;
  localparam int FLAG_L = 4;

  // RR extended opcodes with a defined ALU operation:
  // AND OR XOR ADD ADDU ADDC SUB SUBC CMP MOV MUL. Everything else is a NOP.
  function automatic logic rr_ext_valid(input logic [3:0] ext);
    logic [15:0] valid_mask;
    valid_mask = 16'h6EEE;
    return valid_mask[ext];
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] val);
    return {{8{val[7]}}, val};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval
// Purely combinational evaluation of a CR16 branch condition against the
// datapath flags.
//   flags  in  5  [0]Z [1]N [2]F [3]C [4]L
//   cond   in  4  condition code field
//   taken  out 1  condition holds
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [4:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic z, n, f, c, l;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign f = flags[FLAG_F];
  assign c = flags[FLAG_C];
  assign l = flags[FLAG_L];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_CS: taken = c;
      CC_CC: taken = !c;
      CC_HI: taken = l;
      CC_LS: taken = !l;
      CC_GT: taken = n;
      CC_LE: taken = !n;
      CC_FS: taken = f;
      CC_FC: taken = !f;
      CC_LO: taken = !l && !z;
      CC_HS: taken = l || z;
      CC_LT: taken = !n && !z;
      CC_GE: taken = n || z;
      CC_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// datapath_controller
// Multi-cycle fetch/decode/execute controller for a CR16-style register-file
// and ALU datapath sharing one instruction/data memory. Owns PC and IR.
//   clk, reset (async, active-low)
//   mem_rdata in   memory read data, one cycle after mem_addr
//   mux_a_in  in   datapath A mux (store data)
//   mux_b_in  in   datapath B mux (load/store address, jump target)
//   flags     in   [0]Z [1]N [2]F [3]C [4]L
//   mem_addr, mem_we, mem_wdata                  memory side
//   regEnable, a_select, b_select, use_imm,
//   immediate, opCode, flagsEn, bus_select       datapath control
//   pc_out                                       current PC for trace
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_FETCH   | mem_addr = pc, memory read in flight
// ST_DECODE  | IR <= mem_rdata, pc <= pc + 1
// ST_EXEC    | drive datapath controls for IR; branches update pc
// ST_LOAD_WB | load data on write bus, write Rdest
module datapath_controller
  import ctrl_pkg::*;
#(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       mem_rdata,
  input  logic [15:0]       mux_a_in,
  input  logic [15:0]       mux_b_in,
  input  logic [4:0]        flags,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  output logic [15:0]       regEnable,
  output logic [3:0]        a_select,
  output logic [3:0]        b_select,
  output logic              use_imm,
  output logic [15:0]       immediate,
  output logic [7:0]        opCode,
  output logic              flagsEn,
  output logic              bus_select,
  output logic [ADDR_W-1:0] pc_out
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [15:0]       ir;

  logic [3:0]  op, rd, ext, rs;
  logic        is_rr, is_ls, is_bcond, is_imm;
  logic        taken;
  logic [15:0] dest_onehot;
  logic [ADDR_W-1:0] disp;
  logic [ADDR_W-1:0] mem_target;

  assign op  = ir[15:12];
  assign rd  = ir[11:8];
  assign ext = ir[7:4];
  assign rs  = ir[3:0];

  assign is_rr    = (op == OP_RR) && rr_ext_valid(ext);
  assign is_ls    = (op == OP_LOADSTORE);
  assign is_bcond = (op == OP_BCOND);
  // every major opcode outside the RR, load/store and Bcond groups is an ALU immediate
  assign is_imm   = (op != OP_RR) && !is_ls && !is_bcond;

  assign dest_onehot = 16'h0001 << rd;
  assign disp        = {{(ADDR_W-8){ir[7]}}, ir[7:0]};
  assign mem_target  = mux_b_in[ADDR_W-1:0];

  cond_eval u_cond_eval (
    .flags (flags),
    .cond  (rd),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == ST_DECODE) ir <= mem_rdata;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    mem_addr   = pc;
    mem_we     = 1'b0;
    regEnable  = 16'h0000;
    flagsEn    = 1'b0;
    bus_select = 1'b0;
    use_imm    = 1'b0;
    case (state)
      ST_FETCH: state_next = ST_DECODE;
      ST_DECODE: begin
        state_next = ST_EXEC;
        pc_next    = pc + ADDR_W'(1);
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        if (is_rr) begin
          flagsEn = 1'b1;
          if (ext != EXT_CMP) regEnable = dest_onehot;
        end else if (is_imm) begin
          use_imm = 1'b1;
          flagsEn = 1'b1;
          if (op != OP_CMPI) regEnable = dest_onehot;
        end else if (is_ls) begin
          case (ext)
            EXT_LOAD: begin
              mem_addr   = mem_target;
              state_next = ST_LOAD_WB;
            end
            EXT_STOR: begin
              mem_addr = mem_target;
              mem_we   = 1'b1;
            end
            EXT_JAL: begin
              regEnable  = dest_onehot;
              bus_select = 1'b1;
              pc_next    = mem_target;
            end
            EXT_JCOND: begin
              if (taken) pc_next = mem_target;
            end
            default: ;
          endcase
        end else if (is_bcond) begin
          // pc already points past the branch, so the displacement is relative to pc+1
          if (taken) pc_next = pc + disp;
        end
      end
      ST_LOAD_WB: begin
        state_next = ST_FETCH;
        bus_select = 1'b1;
        regEnable  = dest_onehot;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // RR and load/store groups carry a sub-opcode in instr[7:4]; elsewhere that field is data
  assign opCode    = ((op == OP_RR) || is_ls) ? {op, ext} : {op, 4'b0000};
  assign immediate = sext8(ir[7:0]);
  assign a_select  = rd;
  assign b_select  = rs;
  assign mem_wdata = mux_a_in;
  assign pc_out    = pc;

endmodule
